// File: rtl/mips_pkg.sv
// Shared types and constants for the memory stage: branch encodings,
// memory-access FSM states and the EX/MEM register payload.
package mips_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_EQ   = 4'd1,
        BR_NE   = 4'd2,
        BR_LTZ  = 4'd3,
        BR_GEZ  = 4'd4,
        BR_J    = 4'd5,
        BR_JR   = 4'd6
    } branch_type_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_t;

    // Load data substituted when an access times out
    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0]  alu_out;
        logic [31:0]  write_data;
        logic [4:0]   write_reg;
        logic         reg_write;
        logic         mem_to_reg;
        logic         mem_write;
        logic         branch;
        logic         zero;
        logic [31:0]  pc_branch;
        logic [31:0]  jump_addr;
        branch_type_t branch_type;
    } exmem_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
interface memory_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolution: decides whether fetch is redirected
// and to which target. Shared with the early-branch decode variant.
module branch_resolve
    import mips_pkg::*;
(
    input  branch_type_t branch_type,
    input  logic         branch,
    input  logic         zero,
    input  logic         alu_msb,
    input  logic [31:0]  pc_branch,
    input  logic [31:0]  jump_addr,
    output logic         pc_src_c,
    output logic [31:0]  pc_target_c
);

    always_comb begin
        pc_src_c    = 1'b0;
        pc_target_c = pc_branch;
        case (branch_type)
            BR_EQ:  pc_src_c = branch & zero;
            BR_NE:  pc_src_c = branch & ~zero;
            BR_LTZ: pc_src_c = branch & alu_msb;
            BR_GEZ: pc_src_c = branch & ~alu_msb;
            BR_J, BR_JR: begin
                pc_src_c    = branch;
                pc_target_c = jump_addr;
            end
            default: pc_src_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: EX/MEM register, data-memory access FSM and branch redirect.
// Optional MEM_TIMEOUT_EN adds an access timeout with a sticky error flag.
module memory_stage
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          alu_out_e,
    input  logic [31:0]          write_data_e,
    input  logic [4:0]           write_reg_e,
    input  logic                 reg_write_e,
    input  logic                 mem_to_reg_e,
    input  logic                 mem_write_e,
    input  logic                 branch_e,
    input  logic                 zero_e,
    input  logic [31:0]          pc_branch_e,
    input  logic [31:0]          jump_addr_e,
    input  logic [3:0]           branch_type_e,
    memory_stage_if.master       dmem,
    output logic                 stall_m,
    output logic [31:0]          alu_out_m,
    output logic [31:0]          read_data_m,
    output logic [4:0]           write_reg_m,
    output logic                 reg_write_m,
    output logic                 mem_to_reg_m,
    output logic                 pc_src_m,
    output logic [31:0]          pc_target_m,
    output logic                 mem_err_m
);

    exmem_t     ex_e;
    exmem_t     ex_m;
    mem_state_t state;
    mem_state_t state_nxt;
    logic       in_access;
    logic       mem_op_e;
    logic       is_load_m;
    logic       tmo_hit;
    logic       br_src_c;

    assign ex_e = '{
        alu_out:     alu_out_e,
        write_data:  write_data_e,
        write_reg:   write_reg_e,
        reg_write:   reg_write_e,
        mem_to_reg:  mem_to_reg_e,
        mem_write:   mem_write_e,
        branch:      branch_e,
        zero:        zero_e,
        pc_branch:   pc_branch_e,
        jump_addr:   jump_addr_e,
        branch_type: branch_type_t'(branch_type_e)
    };

    // Stall is a pure state decode so dmem_ack never reaches upstream combinationally
    assign in_access = (state == ACCESS);
    assign mem_op_e  = mem_write_e | mem_to_reg_e;
    // Store wins when both memory controls are set
    assign is_load_m = ex_m.mem_to_reg & ~ex_m.mem_write;

    // EX/MEM register, frozen while an access is outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_m <= '0;
        end else if (!in_access) begin
            ex_m <= ex_e;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        stall_m         = 1'b0;
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_wdata = '0;
        case (state)
            IDLE, RESP: state_nxt = mem_op_e ? ACCESS : IDLE;
            ACCESS: begin
                stall_m         = 1'b1;
                dmem.dmem_req   = 1'b1;
                dmem.dmem_we    = ex_m.mem_write;
                dmem.dmem_addr  = ADDR_W'({ex_m.alu_out[31:2], 2'b00});
                dmem.dmem_wdata = DATA_W'(ex_m.write_data);
                if (dmem.dmem_ack || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_m <= '0;
        end else if (in_access) begin
            if (dmem.dmem_ack) begin
                if (is_load_m) begin
                    read_data_m <= 32'(dmem.dmem_rdata);
                end
            end else if (tmo_hit) begin
                read_data_m <= DEAD_BEEF;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] tmo_cnt;
    logic       mem_err;

    // Counter is held at zero outside ACCESS, so every entry starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            mem_err <= 1'b0;
        end else begin
            tmo_cnt <= in_access ? tmo_cnt + 8'd1 : 8'd0;
            if (tmo_hit) begin
                mem_err <= 1'b1;
            end
        end
    end

    assign tmo_hit   = in_access & ~dmem.dmem_ack & (tmo_cnt == TMO_LAST);
    assign mem_err_m = mem_err;
`else
    assign tmo_hit   = 1'b0;
    assign mem_err_m = 1'b0;
`endif

    branch_resolve u_branch_resolve (
        .branch_type (ex_m.branch_type),
        .branch      (ex_m.branch),
        .zero        (ex_m.zero),
        .alu_msb     (ex_m.alu_out[31]),
        .pc_branch   (ex_m.pc_branch),
        .jump_addr   (ex_m.jump_addr),
        .pc_src_c    (br_src_c),
        .pc_target_c (pc_target_m)
    );

    // No redirect while the pipeline is frozen on a memory access
    assign pc_src_m     = br_src_c & ~in_access;
    assign alu_out_m    = ex_m.alu_out;
    assign write_reg_m  = ex_m.write_reg;
    assign reg_write_m  = ex_m.reg_write;
    assign mem_to_reg_m = ex_m.mem_to_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a responder models data memory, a monitor
// checks each access and each branch resolution against queued expectations.
module tb_memory_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out_e, write_data_e, pc_branch_e, jump_addr_e;
    logic [4:0]  write_reg_e;
    logic        reg_write_e, mem_to_reg_e, mem_write_e, branch_e, zero_e;
    logic [3:0]  branch_type_e;
    logic        stall_m, reg_write_m, mem_to_reg_m, pc_src_m, mem_err_m;
    logic [31:0] alu_out_m, read_data_m, pc_target_m;
    logic [4:0]  write_reg_m;

    memory_stage_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

    memory_stage dut (
        .clk(clk), .rst(rst),
        .alu_out_e(alu_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
        .branch_e(branch_e), .zero_e(zero_e), .pc_branch_e(pc_branch_e),
        .jump_addr_e(jump_addr_e), .branch_type_e(branch_type_e),
        .dmem(dmem),
        .stall_m(stall_m), .alu_out_m(alu_out_m), .read_data_m(read_data_m),
        .write_reg_m(write_reg_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .pc_src_m(pc_src_m), .pc_target_m(pc_target_m), .mem_err_m(mem_err_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        m2r;
        logic [4:0]  wreg;
        int          stalls;
        logic        err;
        bit          b2b;
    } exp_t;

    typedef struct {
        int unsigned waitc;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        logic        src;
        logic [31:0] tgt;
    } br_t;

    exp_t sb_q[$];
    rsp_t mem_q[$];
    br_t  br_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   stray    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory: acks after the queued number of wait cycles
    task automatic responder();
        int unsigned cnt = 0;
        forever begin
            @(negedge clk);
            if (stray) begin
                dmem.dmem_ack   = 1'b1;
                dmem.dmem_rdata = 32'hBAD0_BAD0;
            end else if (rst || !dmem.dmem_req) begin
                dmem.dmem_ack = 1'b0;
                cnt = 0;
            end else if (mem_q.size() > 0 && cnt == mem_q[0].waitc) begin
                dmem.dmem_ack   = 1'b1;
                dmem.dmem_rdata = mem_q[0].rdata;
                mem_q.delete(0);
                cnt = 0;
            end else begin
                dmem.dmem_ack = 1'b0;
                cnt++;
            end
        end
    endtask

    task automatic monitor();
        bit   prev = 1'b0;
        int   cnt = 0;
        int   cyc = 0;
        int   last_resp = -10;
        exp_t e;
        br_t  b;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev = 1'b0;
                cnt  = 0;
            end else begin
                if (br_q.size() > 0) begin
                    b = br_q.pop_front();
                    chk("pc_src", 32'(pc_src_m), 32'(b.src));
                    chk("pc_target", pc_target_m, b.tgt);
                end
                if (stall_m) begin
                    chk("pc_src_in_access", 32'(pc_src_m), 32'd0);
                    chk("req_held", 32'(dmem.dmem_req), 32'd1);
                    if (!prev) begin
                        cnt = 1;
                        if (sb_q.size() == 0) begin
                            chk("unexpected_access", 32'd1, 32'd0);
                        end else begin
                            e = sb_q[0];
                            chk("dmem_addr", dmem.dmem_addr, e.addr);
                            chk("dmem_we", 32'(dmem.dmem_we), 32'(e.we));
                            if (e.we) chk("dmem_wdata", dmem.dmem_wdata, e.wdata);
                            if (e.b2b) chk("b2b_gap", 32'(cyc - last_resp), 32'd1);
                        end
                    end else begin
                        cnt++;
                        if (sb_q.size() > 0) chk("addr_stable", dmem.dmem_addr, sb_q[0].addr);
                    end
                end else if (prev) begin
                    last_resp = cyc;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("read_data_m", read_data_m, e.rd);
                        chk("mem_to_reg_m", 32'(mem_to_reg_m), 32'(e.m2r));
                        chk("write_reg_m", 32'(write_reg_m), 32'(e.wreg));
                        chk("stall_cycles", 32'(cnt), 32'(e.stalls));
                        chk("mem_err_m", 32'(mem_err_m), 32'(e.err));
                    end
                end
                prev = stall_m;
            end
        end
    endtask

    task automatic zero_inputs();
        alu_out_e = '0; write_data_e = '0; write_reg_e = '0; reg_write_e = 1'b0;
        mem_to_reg_e = 1'b0; mem_write_e = 1'b0; branch_e = 1'b0; zero_e = 1'b0;
        pc_branch_e = '0; jump_addr_e = '0; branch_type_e = 4'(BR_NONE);
    endtask

    task automatic drive(input logic [31:0] alu, wd, input logic [4:0] wr,
                         input logic rw, m2r, mw, br, z, input branch_type_t bt,
                         input logic [31:0] pcb, ja);
        @(negedge clk);
        alu_out_e = alu; write_data_e = wd; write_reg_e = wr; reg_write_e = rw;
        mem_to_reg_e = m2r; mem_write_e = mw; branch_e = br; zero_e = z;
        branch_type_e = 4'(bt); pc_branch_e = pcb; jump_addr_e = ja;
    endtask

    // Returns just after the rising edge that loads the driven op
    task automatic capture();
        int n = 0;
        while (stall_m && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("capture_timeout", 32'd1, 32'd0);
        @(posedge clk);
    endtask

    task automatic do_mem(input logic [31:0] alu, wd, input logic [4:0] wr,
                          input logic mw, m2r, input int unsigned waitc,
                          input logic [31:0] rdata, exp_addr, exp_rd,
                          input int exp_stalls, input logic exp_err, input bit b2b,
                          input logic br_j);
        exp_t e;
        drive(alu, wd, wr, m2r, m2r, mw, br_j, 1'b0, br_j ? BR_J : BR_NONE, 32'h0, 32'h1000);
        capture();
        mem_q.push_back('{waitc: waitc, rdata: rdata});
        e.addr = exp_addr; e.we = mw; e.wdata = wd; e.rd = exp_rd; e.m2r = m2r;
        e.wreg = wr; e.stalls = exp_stalls; e.err = exp_err; e.b2b = b2b;
        sb_q.push_back(e);
    endtask

    task automatic do_br(input branch_type_t bt, input logic br, z,
                         input logic [31:0] alu, pcb, ja,
                         input logic exp_src, input logic [31:0] exp_tgt);
        drive(alu, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, br, z, bt, pcb, ja);
        capture();
        br_q.push_back('{src: exp_src, tgt: exp_tgt});
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        zero_inputs();
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        zero_inputs();
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        fork
            responder();
            monitor();
        join_none

        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall_m), 32'd0);
        chk("rst_req", 32'(dmem.dmem_req), 32'd0);
        chk("rst_pc_src", 32'(pc_src_m), 32'd0);
        chk("rst_err", 32'(mem_err_m), 32'd0);
        chk("rst_read_data", read_data_m, 32'd0);
        chk("rst_alu_out", alu_out_m, 32'd0);
        chk("rst_reg_write", 32'(reg_write_m), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load with three wait cycles
        do_mem(32'h0000_0104, 32'h0, 5'd8, 1'b0, 1'b1, 3, 32'h1234_5678,
               32'h0000_0104, 32'h1234_5678, 4, 1'b0, 1'b0, 1'b0);
        idle(6);
        // Store, immediate ack, load data must persist
        do_mem(32'h0000_0020, 32'hCAFE_0001, 5'd0, 1'b1, 1'b0, 0, 32'hFFFF_FFFF,
               32'h0000_0020, 32'h1234_5678, 1, 1'b0, 1'b0, 1'b0);
        idle(4);
        // Back-to-back loads; the second is unaligned and carries a jump
        do_mem(32'h0000_0200, 32'h0, 5'd3, 1'b0, 1'b1, 0, 32'h0A0A_0A0A,
               32'h0000_0200, 32'h0A0A_0A0A, 1, 1'b0, 1'b0, 1'b0);
        do_mem(32'h0000_0207, 32'h0, 5'd4, 1'b0, 1'b1, 2, 32'h55AA_55AA,
               32'h0000_0204, 32'h55AA_55AA, 3, 1'b0, 1'b1, 1'b1);
        idle(6);
        // Both memory controls set behaves as a store
        do_mem(32'h0000_0030, 32'h0000_0077, 5'd9, 1'b1, 1'b1, 1, 32'hFFFF_0000,
               32'h0000_0030, 32'h55AA_55AA, 2, 1'b0, 1'b0, 1'b0);
        idle(4);

        do_br(BR_NE,   1'b1, 1'b0, 32'h0,         32'h40, 32'h400, 1'b1, 32'h40);
        do_br(BR_J,    1'b1, 1'b0, 32'h0,         32'h80, 32'h400, 1'b1, 32'h400);
        do_br(BR_EQ,   1'b1, 1'b0, 32'h0,         32'h44, 32'h400, 1'b0, 32'h44);
        do_br(BR_EQ,   1'b1, 1'b1, 32'h0,         32'h44, 32'h400, 1'b1, 32'h44);
        do_br(BR_LTZ,  1'b1, 1'b0, 32'h8000_0000, 32'h48, 32'h400, 1'b1, 32'h48);
        do_br(BR_GEZ,  1'b1, 1'b0, 32'h8000_0000, 32'h48, 32'h400, 1'b0, 32'h48);
        do_br(BR_JR,   1'b1, 1'b0, 32'h0,         32'h48, 32'h500, 1'b1, 32'h500);
        do_br(BR_NONE, 1'b1, 1'b1, 32'h0,         32'h4C, 32'h500, 1'b0, 32'h4C);
        do_br(BR_J,    1'b0, 1'b0, 32'h0,         32'h50, 32'h600, 1'b0, 32'h600);
        idle(3);

        // Reset in the middle of a long access, then a stray ack
        do_mem(32'h0000_0300, 32'h0, 5'd5, 1'b0, 1'b1, 50, 32'h0000_0099,
               32'h0000_0300, 32'h0000_0099, 51, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(dmem.dmem_req), 32'd0);
        chk("async_rst_stall", 32'(stall_m), 32'd0);
        sb_q.delete();
        mem_q.delete();
        zero_inputs();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1 stray = 1'b1;
        @(negedge clk);
        #1 stray = 1'b0;
        @(negedge clk);
        chk("stray_ack_read_data", read_data_m, 32'd0);
        chk("stray_ack_stall", 32'(stall_m), 32'd0);
        chk("stray_ack_req", 32'(dmem.dmem_req), 32'd0);
        idle(2);

        do_mem(32'h0000_0010, 32'h0, 5'd6, 1'b0, 1'b1, 0, 32'h0BAD_F00D,
               32'h0000_0010, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 1'b0);
        idle(4);
`ifdef MEM_TIMEOUT_EN
        do_mem(32'h0000_0040, 32'h0, 5'd7, 1'b0, 1'b1, 100000, 32'h1111_1111,
               32'h0000_0040, DEAD_BEEF, 255, 1'b1, 1'b0, 1'b0);
        idle(2);
`endif

        n = 0;
        while ((sb_q.size() != 0 || br_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        chk("branch_q_drained", 32'(br_q.size()), 32'd0);
        mem_q.delete();
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
